chain_order_engine: RTL and testbench
=====================================

// Module: chain_order_engine
// PURPOSE
// - Dynamic-programming controller for the matrix-chain multiplier. Sits directly upstream of
//   solution_mat, the 31x31 cost/split table, which it drives through that table's port list.
// - Holds the dimension vector p[0..n]. Walks chain lengths L=2..n, reads m[i][k] and m[k+1][j],
//   computes the minimum cost and best split, and writes both back to the table.
// - Parenthesisation readback uses the table's out/in/jin ports and is outside this block.
// PARAMETERS
// - N_MAX   31   maximum number of matrices; must not exceed the table size
// - DIMW    16   width of each dimension p[x]
// - DW      32   cost/split word width; matches the table
// PORTS
// - clk        in   1     rising-edge clock
// - rst        in   1     asynchronous, active-low reset
// - start      in   1     begin solve; sampled only in IDLE
// - n          in   8     number of matrices, sampled with start
// - dim_we     in   1     dimension write strobe; ignored unless IDLE
// - dim_addr   in   5     dimension index 0..N_MAX
// - dim_data   in   DIMW  dimension value
// - busy       out  1     high from start accept until DONE
// - done       out  1     high in IDLE after a completed solve; cleared by next start
// - err        out  1     n>N_MAX on last start
// - tbl_rst    out  1     drives table rst; synchronous, active-high
// - tbl_rw     out  1     table rw: 1=write, 0=read
// - tbl_iw/jw  out  8     write row/col: i, j
// - tbl_ir/jr/kr out 8    read indices: i, j, k
// - tbl_min    out  DW    cost written to m[i][j]
// - tbl_k      out  DW    split written to m[j][i], zero-extended
// - tbl_mik    in   DW    m[i][k]; valid the cycle after the read address is driven
// - tbl_mkj1   in   DW    m[k+1][j]; same timing as tbl_mik
// BEHAVIOUR
// - Reset (rst=0, async): FSM=IDLE. busy, done, err, tbl_rst and tbl_rw=0. All index/data outputs=0.
//   Dimension regs=0.
// - Reset mid-solve aborts at once; any table writes already made stay in the table.
// - Indexing is 0-based: matrix x is p[x] x p[x+1]; cell (i,j) has j=i+L-1.
// - FSM states and transitions:
//   - IDLE: on start with 2<=n<=N_MAX -> CLR. n<=1 -> done=1, err=0, no table activity.
//     n>N_MAX -> done=1, err=1. start while busy is ignored.
//   - CLR: 1 cycle, tbl_rst=1. Load L=2, i=0, k=0, best=all-ones, bestk=0 -> RD.
//   - RD: tbl_rw=0, tbl_ir=i, tbl_jr=j, tbl_kr=k -> EV.
//   - EV: cost = tbl_mik + tbl_mkj1 + p[i]*p[k+1]*p[j+1], computed at full width, saturated to 2^DW-1.
//     If cost < best (strict; ties keep smaller k): best=cost, bestk=k.
//     k<j-1 -> k++, RD. Else -> WR.
//   - WR: tbl_rw=1, iw=i, jw=j, min=best, k=bestk. Advance i, or L++ with i=0 when i+L-1=n-1.
//     Reset best/bestk; k=new i. More cells -> RD, else DONE.
//   - DONE: 1 cycle, busy still high -> IDLE with done=1.
// - tbl_rw is high only in WR; all table outputs are registered (Moore).
// - Latency: done rises 2 + sum over cells (2(L-1)+1) cycles after the start edge.
//   n=2 gives 5 cycles.
// CONFIGURATION
// - CHAIN_CYCCNT_EN defined: adds output cyc_cnt[31:0]. Cleared on start accept, +1 each busy
//   cycle, holds in IDLE, saturates at all-ones, reset 0.
// - CHAIN_CYCCNT_EN undefined: no port, no counter logic; all other behaviour identical.
// TESTING
// - Bench uses a solution_mat model with identical timing.
// - Reset: assert rst=0 mid-solve -> busy=0, done=0, tbl_rw=0 immediately. Next start runs cleanly.
// - n=2, p={10,20,30}:
//   - one WR: iw=0, jw=1, min=6000, k=0
//   - done 5 cycles after start
// - n=3, p={10,30,5,60}:
//   - writes in order: (0,1)=1500 k0; (1,2)=9000 k1; (0,2)=4500 k1
//   - for (0,2), the k=0 candidate 27000 is rejected
// - Tie: n=3, p={1,1,1,1} -> (0,2) min=2, k=0. The smaller k is kept.
// - Saturation: n=3, all p=65535 -> every written min=32'hFFFFFFFF, no wrap.
// - Boundary:
//   - n=1 -> done next cycle, no tbl_rw pulse
//   - n=40 -> err=1, done=1
//   - start and dim_we while busy -> ignored
//   - n=31 completes with 465 writes

Source files
------------

// File: rtl/chain_order_engine_if.sv
// Bus between chain_order_engine and the solution_mat cost/split table.
// master = engine side, slave = table side.
interface chain_order_engine_if #(
  parameter int DW = 32
);
  logic          tbl_rst;
  logic          tbl_rw;
  logic [7:0]    tbl_iw;
  logic [7:0]    tbl_jw;
  logic [7:0]    tbl_ir;
  logic [7:0]    tbl_jr;
  logic [7:0]    tbl_kr;
  logic [DW-1:0] tbl_min;
  logic [DW-1:0] tbl_k;
  logic [DW-1:0] tbl_mik;
  logic [DW-1:0] tbl_mkj1;

  modport master (
    output tbl_rst, tbl_rw, tbl_iw, tbl_jw, tbl_ir, tbl_jr, tbl_kr, tbl_min, tbl_k,
    input  tbl_mik, tbl_mkj1
  );

  modport slave (
    input  tbl_rst, tbl_rw, tbl_iw, tbl_jw, tbl_ir, tbl_jr, tbl_kr, tbl_min, tbl_k,
    output tbl_mik, tbl_mkj1
  );
endinterface

// File: rtl/chain_order_engine.sv
// Matrix-chain DP controller: fills the solution_mat cost/split table for chain lengths 2..n.
// Optional CHAIN_CYCCNT_EN adds a saturating busy-cycle counter output cyc_cnt.
module chain_order_engine #(
  parameter int N_MAX = 31,
  parameter int DIMW  = 16,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [7:0]      n,
  input  logic            dim_we,
  input  logic [4:0]      dim_addr,
  input  logic [DIMW-1:0] dim_data,
  output logic            busy,
  output logic            done,
  output logic            err,
`ifdef CHAIN_CYCCNT_EN
  output logic [31:0]     cyc_cnt,
`endif
  chain_order_engine_if.master tbl
);

  localparam int CW = ((3 * DIMW > DW) ? 3 * DIMW : DW) + 2;

  typedef enum logic [2:0] {IDLE, CLR, RD, EV, WR, DONE} state_t;

  state_t        state, state_nxt;
  logic [DIMW-1:0] p [0:31];
  logic [7:0]    nreg, nreg_nxt;
  logic [7:0]    len, len_nxt;
  logic [7:0]    i, i_nxt;
  logic [7:0]    k, k_nxt;
  logic [7:0]    j, j_nxt;
  logic [DW-1:0] best, best_nxt;
  logic [7:0]    bestk, bestk_nxt;
  logic          busy_nxt, done_nxt, err_nxt, trst_nxt, rw_nxt;
  logic [7:0]    iw_nxt, jw_nxt, ir_nxt, jr_nxt, kr_nxt;
  logic [DW-1:0] min_nxt, kout_nxt;
  logic [4:0]    kp1, jp1;
  logic [CW-1:0] cost_full;
  logic [DW-1:0] cost;

  assign j   = i + len - 8'd1;
  assign kp1 = k[4:0] + 5'd1;
  assign jp1 = j[4:0] + 5'd1;

  // Candidate cost is formed wide so the product never wraps before saturation.
  assign cost_full = CW'(tbl.tbl_mik) + CW'(tbl.tbl_mkj1)
                   + CW'(p[i[4:0]]) * CW'(p[kp1]) * CW'(p[jp1]);
  assign cost = (cost_full > CW'({DW{1'b1}})) ? {DW{1'b1}} : cost_full[DW-1:0];

  always_comb begin
    state_nxt = state;
    nreg_nxt  = nreg;
    len_nxt   = len;
    i_nxt     = i;
    k_nxt     = k;
    best_nxt  = best;
    bestk_nxt = bestk;
    done_nxt  = done;
    err_nxt   = err;
    ir_nxt    = tbl.tbl_ir;
    jr_nxt    = tbl.tbl_jr;
    kr_nxt    = tbl.tbl_kr;
    iw_nxt    = tbl.tbl_iw;
    jw_nxt    = tbl.tbl_jw;
    min_nxt   = tbl.tbl_min;
    kout_nxt  = tbl.tbl_k;

    case (state)
      IDLE: begin
        if (start) begin
          err_nxt = (n > 8'(N_MAX));
          if (n < 8'd2 || n > 8'(N_MAX)) begin
            done_nxt = 1'b1;
          end else begin
            done_nxt  = 1'b0;
            nreg_nxt  = n;
            state_nxt = CLR;
          end
        end
      end
      CLR: begin
        len_nxt   = 8'd2;
        i_nxt     = 8'd0;
        k_nxt     = 8'd0;
        best_nxt  = {DW{1'b1}};
        bestk_nxt = 8'd0;
        state_nxt = RD;
      end
      RD: state_nxt = EV;
      EV: begin
        if (cost < best) begin
          best_nxt  = cost;
          bestk_nxt = k;
        end
        if (k < j - 8'd1) begin
          k_nxt     = k + 8'd1;
          state_nxt = RD;
        end else begin
          state_nxt = WR;
        end
      end
      WR: begin
        best_nxt  = {DW{1'b1}};
        bestk_nxt = 8'd0;
        if (j == nreg - 8'd1) begin
          if (len == nreg) begin
            state_nxt = DONE;
          end else begin
            len_nxt   = len + 8'd1;
            i_nxt     = 8'd0;
            state_nxt = RD;
          end
        end else begin
          i_nxt     = i + 8'd1;
          state_nxt = RD;
        end
        k_nxt = i_nxt;
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Table outputs are decoded from the next state so they come straight off flops.
    j_nxt    = i_nxt + len_nxt - 8'd1;
    busy_nxt = (state_nxt != IDLE);
    trst_nxt = (state_nxt == CLR);
    rw_nxt   = (state_nxt == WR);
    if (state_nxt == RD) begin
      ir_nxt = i_nxt;
      jr_nxt = j_nxt;
      kr_nxt = k_nxt;
    end
    if (state_nxt == WR) begin
      iw_nxt   = i_nxt;
      jw_nxt   = j_nxt;
      min_nxt  = best_nxt;
      kout_nxt = DW'(bestk_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      nreg        <= 8'd0;
      len         <= 8'd0;
      i           <= 8'd0;
      k           <= 8'd0;
      best        <= '0;
      bestk       <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      tbl.tbl_rst <= 1'b0;
      tbl.tbl_rw  <= 1'b0;
      tbl.tbl_ir  <= 8'd0;
      tbl.tbl_jr  <= 8'd0;
      tbl.tbl_kr  <= 8'd0;
      tbl.tbl_iw  <= 8'd0;
      tbl.tbl_jw  <= 8'd0;
      tbl.tbl_min <= '0;
      tbl.tbl_k   <= '0;
      for (int x = 0; x < 32; x++) p[x] <= '0;
    end else begin
      state       <= state_nxt;
      nreg        <= nreg_nxt;
      len         <= len_nxt;
      i           <= i_nxt;
      k           <= k_nxt;
      best        <= best_nxt;
      bestk       <= bestk_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
      tbl.tbl_rst <= trst_nxt;
      tbl.tbl_rw  <= rw_nxt;
      tbl.tbl_ir  <= ir_nxt;
      tbl.tbl_jr  <= jr_nxt;
      tbl.tbl_kr  <= kr_nxt;
      tbl.tbl_iw  <= iw_nxt;
      tbl.tbl_jw  <= jw_nxt;
      tbl.tbl_min <= min_nxt;
      tbl.tbl_k   <= kout_nxt;
      if (state == IDLE && dim_we) p[dim_addr] <= dim_data;
    end
  end

`ifdef CHAIN_CYCCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt <= 32'd0;
    end else if (state == IDLE && state_nxt == CLR) begin
      cyc_cnt <= 32'd0;
    end else if (busy && cyc_cnt != 32'hFFFF_FFFF) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_chain_order_engine.sv
// Bench for chain_order_engine: solution_mat table model, textbook DP reference, directed + random runs.
module tb_chain_order_engine;

  typedef struct {
    int     i;
    int     j;
    longint mn;
    longint k;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  n;
  logic        dim_we;
  logic [4:0]  dim_addr;
  logic [15:0] dim_data;
  logic        busy;
  logic        done;
  logic        err;
`ifdef CHAIN_CYCCNT_EN
  logic [31:0] cyc_cnt;
`endif

  chain_order_engine_if #(.DW(32)) tbl_if ();

  chain_order_engine #(.N_MAX(31), .DIMW(16), .DW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n        (n),
    .dim_we   (dim_we),
    .dim_addr (dim_addr),
    .dim_data (dim_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
`ifdef CHAIN_CYCCNT_EN
    .cyc_cnt  (cyc_cnt),
`endif
    .tbl      (tbl_if)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cycles;
  int          exp_lat;
  logic        busy_after_start;
  logic [15:0] dims [0:31];
  logic [31:0] mtab [0:31][0:31];
  wr_t         obs_q[$];
  wr_t         exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // solution_mat model: synchronous clear, write m[i][j] and split into m[j][i], registered reads.
  always @(posedge clk) begin
    if (tbl_if.tbl_rst) begin
      for (int a = 0; a < 32; a++)
        for (int b = 0; b < 32; b++) mtab[a][b] <= 32'd0;
    end else if (tbl_if.tbl_rw) begin
      mtab[tbl_if.tbl_iw[4:0]][tbl_if.tbl_jw[4:0]] <= tbl_if.tbl_min;
      mtab[tbl_if.tbl_jw[4:0]][tbl_if.tbl_iw[4:0]] <= tbl_if.tbl_k;
    end
    tbl_if.tbl_mik  <= mtab[tbl_if.tbl_ir[4:0]][tbl_if.tbl_kr[4:0]];
    tbl_if.tbl_mkj1 <= mtab[tbl_if.tbl_kr[4:0] + 5'd1][tbl_if.tbl_jr[4:0]];
  end

  always @(posedge clk) begin
    if (tbl_if.tbl_rw)
      obs_q.push_back('{int'(tbl_if.tbl_iw), int'(tbl_if.tbl_jw),
                        longint'(tbl_if.tbl_min), longint'(tbl_if.tbl_k)});
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Textbook matrix-chain DP with saturating costs; strict < over ascending k keeps the smaller split.
  task automatic build_model(input int nn);
    longint mm [0:31][0:31];
    longint cost;
    longint best;
    longint bestk;
    int     b;
    exp_q.delete();
    exp_lat = 2;
    for (int a = 0; a < 32; a++)
      for (int c = 0; c < 32; c++) mm[a][c] = 0;
    for (int len = 2; len <= nn; len++) begin
      for (int a = 0; a + len - 1 < nn; a++) begin
        b     = a + len - 1;
        best  = 64'hFFFF_FFFF;
        bestk = 0;
        for (int c = a; c < b; c++) begin
          cost = mm[a][c] + mm[c+1][b]
               + longint'(dims[a]) * longint'(dims[c+1]) * longint'(dims[b+1]);
          if (cost > 64'hFFFF_FFFF) cost = 64'hFFFF_FFFF;
          if (cost < best) begin
            best  = cost;
            bestk = c;
          end
        end
        mm[a][b] = best;
        exp_q.push_back('{a, b, best, bestk});
        exp_lat += 2 * (len - 1) + 1;
      end
    end
  endtask

  task automatic applyStimulus(input int nn, input bit interfere);
    for (int x = 0; x <= nn && x < 32; x++) begin
      @(negedge clk);
      dim_we   = 1'b1;
      dim_addr = 5'(x);
      dim_data = dims[x];
    end
    @(negedge clk);
    dim_we = 1'b0;
    if (nn >= 2 && nn <= 31) build_model(nn);
    else exp_q.delete();
    obs_q.delete();
    start = 1'b1;
    n     = 8'(nn);
    @(negedge clk);
    start            = 1'b0;
    busy_after_start = busy;
    cycles           = 0;
    while (!done && cycles < 20000) begin
      if (interfere && cycles == 2) begin
        start    = 1'b1;
        n        = 8'd5;
        dim_we   = 1'b1;
        dim_addr = 5'd1;
        dim_data = 16'hBEEF;
      end else begin
        start  = 1'b0;
        dim_we = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start  = 1'b0;
    dim_we = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput($sformatf("n%0d.done", nn), done, 1'b1);
    checkOutput($sformatf("n%0d.busy_end", nn), busy, 1'b0);
    if (nn >= 2 && nn <= 31) begin
      checkOutput($sformatf("n%0d.busy_start", nn), busy_after_start, 1'b1);
      checkOutput($sformatf("n%0d.err", nn), err, 1'b0);
      checkOutput($sformatf("n%0d.latency", nn), cycles, exp_lat);
`ifdef CHAIN_CYCCNT_EN
      checkOutput($sformatf("n%0d.cyc_cnt", nn), cyc_cnt, exp_lat);
`endif
      checkOutput($sformatf("n%0d.wr_count", nn), obs_q.size(), exp_q.size());
      for (int w = 0; w < exp_q.size() && w < obs_q.size(); w++) begin
        checkOutput($sformatf("n%0d.wr%0d.i", nn, w), obs_q[w].i, exp_q[w].i);
        checkOutput($sformatf("n%0d.wr%0d.j", nn, w), obs_q[w].j, exp_q[w].j);
        checkOutput($sformatf("n%0d.wr%0d.min", nn, w), obs_q[w].mn, exp_q[w].mn);
        checkOutput($sformatf("n%0d.wr%0d.k", nn, w), obs_q[w].k, exp_q[w].k);
      end
    end else begin
      checkOutput($sformatf("n%0d.busy_start", nn), busy_after_start, 1'b0);
      checkOutput($sformatf("n%0d.latency", nn), cycles, 0);
      checkOutput($sformatf("n%0d.err", nn), err, (nn > 31) ? 1'b1 : 1'b0);
      checkOutput($sformatf("n%0d.no_writes", nn), obs_q.size(), 0);
    end
  endtask

  task automatic set_dims(input int lo, input int hi);
    for (int x = 0; x < 32; x++) dims[x] = 16'($urandom_range(hi, lo));
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    n        = 8'd0;
    dim_we   = 1'b0;
    dim_addr = 5'd0;
    dim_data = 16'd0;
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst.busy", busy, 1'b0);
    checkOutput("rst.done", done, 1'b0);
    checkOutput("rst.err", err, 1'b0);
    checkOutput("rst.tbl_rst", tbl_if.tbl_rst, 1'b0);
    checkOutput("rst.tbl_rw", tbl_if.tbl_rw, 1'b0);
    checkOutput("rst.tbl_iw", tbl_if.tbl_iw, 8'd0);
    checkOutput("rst.tbl_min", tbl_if.tbl_min, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] n=1");
    set_dims(1, 100);
    applyStimulus(1, 1'b0);

    $display("[TB] n=2 p={10,20,30}");
    dims[0] = 16'd10; dims[1] = 16'd20; dims[2] = 16'd30;
    applyStimulus(2, 1'b0);
    checkOutput("n2.latency_const", cycles, 5);
    checkOutput("n2.count_const", obs_q.size(), 1);
    if (obs_q.size() >= 1) begin
      checkOutput("n2.iw", obs_q[0].i, 0);
      checkOutput("n2.jw", obs_q[0].j, 1);
      checkOutput("n2.min", obs_q[0].mn, 6000);
      checkOutput("n2.k", obs_q[0].k, 0);
    end

    $display("[TB] n=3 p={10,30,5,60}");
    dims[0] = 16'd10; dims[1] = 16'd30; dims[2] = 16'd5; dims[3] = 16'd60;
    applyStimulus(3, 1'b0);
    checkOutput("n3.count_const", obs_q.size(), 3);
    if (obs_q.size() >= 3) begin
      checkOutput("n3.c01.min", obs_q[0].mn, 1500);
      checkOutput("n3.c01.k", obs_q[0].k, 0);
      checkOutput("n3.c12.min", obs_q[1].mn, 9000);
      checkOutput("n3.c12.k", obs_q[1].k, 1);
      checkOutput("n3.c02.min", obs_q[2].mn, 4500);
      checkOutput("n3.c02.k", obs_q[2].k, 1);
    end

    $display("[TB] tie p={1,1,1,1}");
    for (int x = 0; x < 4; x++) dims[x] = 16'd1;
    applyStimulus(3, 1'b0);
    if (obs_q.size() >= 3) begin
      checkOutput("tie.c02.min", obs_q[2].mn, 2);
      checkOutput("tie.c02.k", obs_q[2].k, 0);
    end

    $display("[TB] saturation p=65535");
    for (int x = 0; x < 4; x++) dims[x] = 16'hFFFF;
    applyStimulus(3, 1'b0);
    for (int w = 0; w < obs_q.size(); w++)
      checkOutput($sformatf("sat.wr%0d.min", w), obs_q[w].mn, 32'hFFFF_FFFF);

    $display("[TB] start/dim_we while busy");
    set_dims(1, 50);
    applyStimulus(3, 1'b1);

    $display("[TB] random chains");
    for (int t = 0; t < 4; t++) begin
      if (t % 2 == 0) set_dims(0, 65535);
      else set_dims(1, 200);
      applyStimulus($urandom_range(8, 2), 1'b0);
    end

    $display("[TB] reset mid-solve");
    set_dims(1, 100);
    for (int x = 0; x <= 10; x++) begin
      @(negedge clk);
      dim_we   = 1'b1;
      dim_addr = 5'(x);
      dim_data = dims[x];
    end
    @(negedge clk);
    dim_we = 1'b0;
    start  = 1'b1;
    n      = 8'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (37) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst.busy", busy, 1'b0);
    checkOutput("midrst.done", done, 1'b0);
    checkOutput("midrst.tbl_rw", tbl_if.tbl_rw, 1'b0);
    checkOutput("midrst.tbl_iw", tbl_if.tbl_iw, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] n=40");
    applyStimulus(40, 1'b0);

    $display("[TB] clean run after reset/err");
    set_dims(1, 1000);
    applyStimulus(4, 1'b0);

    $display("[TB] n=31");
    set_dims(1, 300);
    applyStimulus(31, 1'b0);
    checkOutput("n31.writes", obs_q.size(), 465);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
